bram_fetch_sequencer: RTL and testbench



---
 rtl/bram_fetch_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_bram_fetch_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fetch_sequencer.sv
// Four-bank parity-split BRAM read sequencer with 2x2 neighbourhood swizzle and a credit-controlled output FIFO.
// Optional statistics counters are built only when BRAM_FETCH_STATS_EN is defined.
module bram_fetch_sequencer #(
    parameter int ADDR_W     = 12,
    parameter int ROW_W      = 3,
    parameter int PIX_W      = 8,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    output logic                    idle,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_W-1:0]       addr_oo,
    input  logic [ADDR_W-1:0]       addr_oe,
    input  logic [ADDR_W-1:0]       addr_eo,
    input  logic [ADDR_W-1:0]       addr_ee,
    input  logic [ROW_W-1:0]        row_oo,
    input  logic [ROW_W-1:0]        row_oe,
    input  logic [ROW_W-1:0]        row_eo,
    input  logic [ROW_W-1:0]        row_ee,
    input  logic                    odd_pixel,
    input  logic                    odd_row,
    output logic                    bram_en,
    output logic [ROW_W+ADDR_W-1:0] bram_addr_oo,
    output logic [ROW_W+ADDR_W-1:0] bram_addr_oe,
    output logic [ROW_W+ADDR_W-1:0] bram_addr_eo,
    output logic [ROW_W+ADDR_W-1:0] bram_addr_ee,
    input  logic [PIX_W-1:0]        bram_rdata_oo,
    input  logic [PIX_W-1:0]        bram_rdata_oe,
    input  logic [PIX_W-1:0]        bram_rdata_eo,
    input  logic [PIX_W-1:0]        bram_rdata_ee,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PIX_W-1:0]        out_tl,
    output logic [PIX_W-1:0]        out_tr,
    output logic [PIX_W-1:0]        out_bl,
    output logic [PIX_W-1:0]        out_br,
    output logic [31:0]             stat_fetches,
    output logic [31:0]             stat_stalls
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NB_W  = 4 * PIX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              fifo_wr_s;
    logic              fifo_pop_s;
    logic [CNT_W-1:0]  outstanding_s;
    logic [CNT_W-1:0]  inflight_r;
    logic [CNT_W-1:0]  inflight_s;
    logic [CNT_W-1:0]  fifo_cnt_r;
    logic [CNT_W-1:0]  fifo_cnt_s;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [NB_W-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [NB_W-1:0]   wr_data_s;
    logic [RD_LAT-1:0] pipe_vld_r;
    logic [RD_LAT-1:0] pipe_odd_pixel_r;
    logic [RD_LAT-1:0] pipe_odd_row_r;

    // Bank indexed by {row parity, column parity}, 1 = odd.
    function automatic logic [PIX_W-1:0] pick_bank(
        input logic             row_odd,
        input logic             col_odd,
        input logic [PIX_W-1:0] oo,
        input logic [PIX_W-1:0] oe,
        input logic [PIX_W-1:0] eo,
        input logic [PIX_W-1:0] ee
    );
        logic [PIX_W-1:0] pix;
        case ({row_odd, col_odd})
            2'b11:   pix = oo;
            2'b10:   pix = oe;
            2'b01:   pix = eo;
            2'b00:   pix = ee;
            default: pix = {PIX_W{1'b0}};
        endcase
        return pix;
    endfunction

    assign bram_addr_oo  = {row_oo, addr_oo};
    assign bram_addr_oe  = {row_oe, addr_oe};
    assign bram_addr_eo  = {row_eo, addr_eo};
    assign bram_addr_ee  = {row_ee, addr_ee};
    assign outstanding_s = inflight_r + fifo_cnt_r;
    assign accept_s      = in_valid && in_ready_s;
    assign fifo_wr_s     = pipe_vld_r[RD_LAT-1];
    assign fifo_pop_s    = out_valid && out_ready;
    assign bram_en       = accept_s;
    assign in_ready      = in_ready_s;
    assign idle          = (state_r == ST_IDLE);
    assign out_valid     = (fifo_cnt_r != {CNT_W{1'b0}});
    assign {out_tl, out_tr, out_bl, out_br} = fifo_mem_r[rd_ptr_r];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and accept gating; enable wins over draining to idle
    always_comb begin
        state_s    = state_r;
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_s = ST_RUN;
                else        state_s = ST_IDLE;
            end
            ST_RUN: begin
                in_ready_s = enable && (outstanding_s < DEPTH_C);
                if (!enable) state_s = ST_DRAIN;
                else         state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (enable)                                 state_s = ST_RUN;
                else if (outstanding_s == {CNT_W{1'b0}})    state_s = ST_IDLE;
                else                                        state_s = ST_DRAIN;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Read-latency pipeline carrying validity and source parity alongside each read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_r       <= {RD_LAT{1'b0}};
            pipe_odd_pixel_r <= {RD_LAT{1'b0}};
            pipe_odd_row_r   <= {RD_LAT{1'b0}};
        end else begin
            pipe_vld_r[0]       <= accept_s;
            pipe_odd_pixel_r[0] <= odd_pixel;
            pipe_odd_row_r[0]   <= odd_row;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld_r[k]       <= pipe_vld_r[k-1];
                pipe_odd_pixel_r[k] <= pipe_odd_pixel_r[k-1];
                pipe_odd_row_r[k]   <= pipe_odd_row_r[k-1];
            end
        end
    end

    // Swizzle returning bank data into tl/tr/bl/br; top row parity = odd_row, left column parity = odd_pixel
    always_comb begin
        logic op_s;
        logic or_s;
        op_s = pipe_odd_pixel_r[RD_LAT-1];
        or_s = pipe_odd_row_r[RD_LAT-1];
        wr_data_s = {
            pick_bank( or_s,  op_s, bram_rdata_oo, bram_rdata_oe, bram_rdata_eo, bram_rdata_ee),
            pick_bank( or_s, !op_s, bram_rdata_oo, bram_rdata_oe, bram_rdata_eo, bram_rdata_ee),
            pick_bank(!or_s,  op_s, bram_rdata_oo, bram_rdata_oe, bram_rdata_eo, bram_rdata_ee),
            pick_bank(!or_s, !op_s, bram_rdata_oo, bram_rdata_oe, bram_rdata_eo, bram_rdata_ee)
        };
    end

    // Credit bookkeeping: in-flight and FIFO occupancy each move by at most one per cycle
    always_comb begin
        inflight_s = inflight_r;
        fifo_cnt_s = fifo_cnt_r;
        case ({accept_s, fifo_wr_s})
            2'b10:   inflight_s = inflight_r + CNT_ONE;
            2'b01:   inflight_s = inflight_r - CNT_ONE;
            default: inflight_s = inflight_r;
        endcase
        case ({fifo_wr_s, fifo_pop_s})
            2'b10:   fifo_cnt_s = fifo_cnt_r + CNT_ONE;
            2'b01:   fifo_cnt_s = fifo_cnt_r - CNT_ONE;
            default: fifo_cnt_s = fifo_cnt_r;
        endcase
    end

    // Output FIFO storage, pointers and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= {CNT_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {NB_W{1'b0}};
            end
        end else begin
            inflight_r <= inflight_s;
            fifo_cnt_r <= fifo_cnt_s;
            if (fifo_wr_s) begin
                fifo_mem_r[wr_ptr_r] <= wr_data_s;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

`ifdef BRAM_FETCH_STATS_EN
    logic [31:0] stat_fetches_r;
    logic [31:0] stat_stalls_r;

    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetches_r <= 32'd0;
            stat_stalls_r  <= 32'd0;
        end else begin
            if (accept_s) stat_fetches_r <= stat_fetches_r + 32'd1;
            if (out_valid && !out_ready) stat_stalls_r <= stat_stalls_r + 32'd1;
        end
    end

    assign stat_fetches = stat_fetches_r;
    assign stat_stalls  = stat_stalls_r;
`else
    assign stat_fetches = 32'd0;
    assign stat_stalls  = 32'd0;
`endif

endmodule

// File: tb/tb_bram_fetch_sequencer.sv
// Randomized self-checking bench for bram_fetch_sequencer: a BRAM model with fixed read latency and
// a transaction-level scoreboard that predicts each neighbourhood from the accepted coordinate.
module tb_bram_fetch_sequencer;

    localparam int ADDR_W     = 12;
    localparam int ROW_W      = 3;
    localparam int PIX_W      = 8;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int AW         = ROW_W + ADDR_W;
    localparam int M_IDLE     = 0;
    localparam int M_RUN      = 1;
    localparam int M_DRAIN    = 2;

    typedef struct {
        logic [31:0] pix;
        int          rdy;
    } exp_t;

    exp_t q[$];

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              in_valid;
    logic              out_ready;
    logic              odd_pixel;
    logic              odd_row;
    logic [ADDR_W-1:0] addr_in [4];
    logic [ROW_W-1:0]  row_in  [4];
    logic              idle, in_ready, bram_en, out_valid;
    logic [AW-1:0]     bram_addr_oo, bram_addr_oe, bram_addr_eo, bram_addr_ee;
    logic [PIX_W-1:0]  out_tl, out_tr, out_bl, out_br;
    logic [31:0]       stat_fetches, stat_stalls;
    logic [PIX_W-1:0]  d1 [4];
    logic [PIX_W-1:0]  d2 [4];

    int n_cmp   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int mode    = M_IDLE;
    int n_acc   = 0;
    int n_stall = 0;
    int obs_en  = 0;
    int obs_pop = 0;

    bram_fetch_sequencer #(
        .ADDR_W(ADDR_W), .ROW_W(ROW_W), .PIX_W(PIX_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .idle(idle),
        .in_valid(in_valid), .in_ready(in_ready),
        .addr_oo(addr_in[0]), .addr_oe(addr_in[1]), .addr_eo(addr_in[2]), .addr_ee(addr_in[3]),
        .row_oo(row_in[0]), .row_oe(row_in[1]), .row_eo(row_in[2]), .row_ee(row_in[3]),
        .odd_pixel(odd_pixel), .odd_row(odd_row),
        .bram_en(bram_en),
        .bram_addr_oo(bram_addr_oo), .bram_addr_oe(bram_addr_oe),
        .bram_addr_eo(bram_addr_eo), .bram_addr_ee(bram_addr_ee),
        .bram_rdata_oo(d2[0]), .bram_rdata_oe(d2[1]), .bram_rdata_eo(d2[2]), .bram_rdata_ee(d2[3]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tl(out_tl), .out_tr(out_tr), .out_bl(out_bl), .out_br(out_br),
        .stat_fetches(stat_fetches), .stat_stalls(stat_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of bank b (0=oo,1=oe,2=eo,3=ee) at address a
    function automatic logic [PIX_W-1:0] mem_word(input int b, input logic [AW-1:0] a);
        logic [31:0] h;
        h = 32'(a) * 32'd40503 + 32'(b) * 32'd12345 + 32'd7;
        h = h ^ (h >> 11);
        return h[PIX_W-1:0];
    endfunction

    // BRAM with RD_LAT=2: data appears two cycles after the strobe
    always @(posedge clk) begin
        if (bram_en) begin
            d1[0] <= mem_word(0, bram_addr_oo);
            d1[1] <= mem_word(1, bram_addr_oe);
            d1[2] <= mem_word(2, bram_addr_eo);
            d1[3] <= mem_word(3, bram_addr_ee);
        end
        d2 <= d1;
    end

    // Pixel of the source bank with row parity r and column parity c, from the current request
    function automatic logic [PIX_W-1:0] bank_pix(input logic r, input logic c);
        int b;
        b = 2 * (r ? 0 : 1) + (c ? 0 : 1);
        return mem_word(b, {row_in[b], addr_in[b]});
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, check against the model, advance the model
    task automatic cycle(input logic en, input logic iv, input logic ordy, input int par);
        logic exp_rdy;
        logic exp_ov;
        logic acc;
        int   sz0;
        exp_t e;
        @(negedge clk);
        enable    = en;
        in_valid  = iv;
        out_ready = ordy;
        if (par < 0) begin
            odd_pixel = 1'($urandom);
            odd_row   = 1'($urandom);
        end else begin
            odd_pixel = par[0];
            odd_row   = par[1];
        end
        for (int b = 0; b < 4; b++) begin
            addr_in[b] = ADDR_W'($urandom);
            row_in[b]  = ROW_W'($urandom);
        end
        #1;
        sz0     = q.size();
        exp_rdy = (mode == M_RUN) && en && (sz0 < FIFO_DEPTH);
        exp_ov  = 1'b0;
        if (sz0 > 0) exp_ov = (q[0].rdy <= cyc);
        check_eq("idle", 32'(idle), 32'(mode == M_IDLE));
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_eq("bram_en", 32'(bram_en), 32'(iv && exp_rdy));
        check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) check_eq("nbhd", {out_tl, out_tr, out_bl, out_br}, q[0].pix);
        if (bram_en) obs_en++;
        if (out_valid && out_ready) obs_pop++;
        acc = iv && exp_rdy;
        e.pix = 32'd0;
        e.rdy = 0;
        if (acc) begin
            check_eq("bram_addr_oo", 32'(bram_addr_oo), 32'({row_in[0], addr_in[0]}));
            check_eq("bram_addr_oe", 32'(bram_addr_oe), 32'({row_in[1], addr_in[1]}));
            check_eq("bram_addr_eo", 32'(bram_addr_eo), 32'({row_in[2], addr_in[2]}));
            check_eq("bram_addr_ee", 32'(bram_addr_ee), 32'({row_in[3], addr_in[3]}));
            e.pix = {bank_pix(odd_row, odd_pixel), bank_pix(odd_row, !odd_pixel),
                     bank_pix(!odd_row, odd_pixel), bank_pix(!odd_row, !odd_pixel)};
            e.rdy = cyc + RD_LAT + 1;
            n_acc++;
        end
        if (exp_ov && ordy) void'(q.pop_front());
        if (exp_ov && !ordy) n_stall++;
        if (acc) q.push_back(e);
        case (mode)
            M_IDLE:  if (en) mode = M_RUN;
            M_RUN:   if (!en) mode = M_DRAIN;
            M_DRAIN: begin
                if (en) mode = M_RUN;
                else if (sz0 == 0) mode = M_IDLE;
            end
            default: mode = M_IDLE;
        endcase
        cyc++;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_idle"}, 32'(idle), 32'd1);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_out_pix"}, {out_tl, out_tr, out_bl, out_br}, 32'd0);
        check_eq({tag, "_stat_fetches"}, stat_fetches, 32'd0);
        check_eq({tag, "_stat_stalls"}, stat_stalls, 32'd0);
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        enable    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        odd_pixel = 1'b0;
        odd_row   = 1'b0;
        for (int b = 0; b < 4; b++) begin
            addr_in[b] = '0;
            row_in[b]  = '0;
        end
        #3;
        check_reset_state("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single coordinate odd_pixel=1, odd_row=0, then all four parity combinations
        cycle(1'b1, 1'b0, 1'b1, -1);
        cycle(1'b1, 1'b1, 1'b1, 1);
        repeat (5) cycle(1'b1, 1'b0, 1'b1, -1);
        for (int p = 0; p < 4; p++) cycle(1'b1, 1'b1, 1'b1, p);
        repeat (6) cycle(1'b1, 1'b0, 1'b1, -1);

        // Sustained throughput
        base = obs_en;
        repeat (100) cycle(1'b1, 1'b1, 1'b1, -1);
        check_eq("stream_accepts", 32'(obs_en - base), 32'd100);
        base = obs_pop;
        repeat (6) cycle(1'b1, 1'b0, 1'b1, -1);
        check_eq("stream_tail_pops", 32'(obs_pop - base), 32'(RD_LAT + 1));

        // Backpressure: credits stop acceptance at FIFO_DEPTH
        base = obs_en;
        repeat (20) cycle(1'b1, 1'b1, 1'b0, -1);
        check_eq("stall_accepts", 32'(obs_en - base), 32'(FIFO_DEPTH));
        base = obs_pop;
        repeat (8) cycle(1'b1, 1'b0, 1'b1, -1);
        check_eq("stall_release_pops", 32'(obs_pop - base), 32'(FIFO_DEPTH));

        // Drain with 3 outstanding, then re-enable during drain
        repeat (3) cycle(1'b1, 1'b1, 1'b0, -1);
        repeat (5) cycle(1'b0, 1'b1, 1'b0, -1);
        repeat (8) cycle(1'b0, 1'b0, 1'b1, -1);
        check_eq("drain_idle", 32'(idle), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, -1);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, -1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, -1);
        repeat (10) cycle(1'b1, 1'b1, 1'b1, -1);
        repeat (6) cycle(1'b1, 1'b0, 1'b1, -1);

        // Random traffic
        repeat (1500) begin
            cycle(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 9) < 6), -1);
        end

        // Asynchronous reset with two entries in the FIFO
        repeat (12) cycle(1'b1, 1'b0, 1'b1, -1);
        repeat (2) cycle(1'b1, 1'b1, 1'b0, -1);
        repeat (4) cycle(1'b1, 1'b0, 1'b0, -1);
        check_eq("pre_reset_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        enable   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        q.delete();
        mode    = M_IDLE;
        n_acc   = 0;
        n_stall = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cycle(1'b0, 1'b0, 1'b1, -1);
        cycle(1'b1, 1'b0, 1'b1, -1);
        repeat (10) cycle(1'b1, 1'b1, 1'b0, -1);
        repeat (10) cycle(1'b1, 1'b1, 1'b1, -1);
        repeat (6) cycle(1'b0, 1'b0, 1'b1, -1);

`ifdef BRAM_FETCH_STATS_EN
        check_eq("stat_fetches", stat_fetches, 32'(n_acc));
        check_eq("stat_stalls", stat_stalls, 32'(n_stall));
`else
        check_eq("stat_fetches", stat_fetches, 32'd0);
        check_eq("stat_stalls", stat_stalls, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
